// File: rtl/axi_lite_periph_responder.sv
// rtl/axi_lite_periph_responder.sv - AXI4-Lite responder with scratch, ID and coherent cycle-counter registers
module axi_lite_periph_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
    parameter int          REG_COUNT = 8,
    parameter logic [31:0] ID_VALUE  = 32'hC5A5_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [9:0] IDX_ID      = 10'(REG_COUNT);
    localparam logic [9:0] IDX_LO      = 10'(REG_COUNT + 1);
    localparam logic [9:0] IDX_HI      = 10'(REG_COUNT + 2);

    typedef enum logic [2:0] {K_SCR, K_ID, K_CNT_LO, K_CNT_HI, K_DEC, K_MIS} kind_e;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_RESP} rstate_e;

    typedef struct packed {
        kind_e      kind;
        logic [9:0] idx;
    } dec_t;

    // Window check wins over alignment so stray addresses always report DECERR
    function automatic dec_t decode(input logic [31:0] addr);
        dec_t        d;
        logic [19:0] page;
        {page, d.idx} = 30'((addr - BASE_ADDR) >> 2);
        if (page != '0)                d.kind = K_DEC;
        else if (addr[1:0] != 2'b00)   d.kind = K_MIS;
        else if (d.idx < IDX_ID)       d.kind = K_SCR;
        else if (d.idx == IDX_ID)      d.kind = K_ID;
        else if (d.idx == IDX_LO)      d.kind = K_CNT_LO;
        else if (d.idx == IDX_HI)      d.kind = K_CNT_HI;
        else                           d.kind = K_DEC;
        return d;
    endfunction

    logic [31:0] scratch [REG_COUNT];
    logic [63:0] counter;
    logic [31:0] shadow;

    wstate_e     w_state, w_next;
    logic        aw_hs, w_hs, w_commit;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] c_addr, c_data;
    logic [3:0]  c_strb;
    dec_t        w_dec;
    logic [1:0]  w_resp, bresp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next    = w_state;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        w_commit  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_awready = 1'b1;
                s_wready  = 1'b1;
                aw_hs     = s_awvalid;
                w_hs      = s_wvalid;
                if (aw_hs && w_hs) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_HAVE_AW;
                end else if (w_hs) begin
                    w_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                s_wready = 1'b1;
                w_hs     = s_wvalid;
                if (w_hs) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_HAVE_W: begin
                s_awready = 1'b1;
                aw_hs     = s_awvalid;
                if (aw_hs) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // The half that arrived earlier comes from the holding registers
    always_comb begin
        c_addr = (w_state == W_HAVE_AW) ? aw_addr_q : s_awaddr;
        c_data = (w_state == W_HAVE_W)  ? w_data_q  : s_wdata;
        c_strb = (w_state == W_HAVE_W)  ? w_strb_q  : s_wstrb;
        w_dec  = decode(c_addr);
        case (w_dec.kind)
            K_SCR:   w_resp = RESP_OKAY;
            K_DEC:   w_resp = RESP_DECERR;
            default: w_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) aw_addr_q <= s_awaddr;
            if (w_hs) begin
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
            if (w_commit) bresp_q <= w_resp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) scratch[i] <= '0;
        end else if (w_commit && w_dec.kind == K_SCR) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (w_dec.idx == 10'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (c_strb[b]) scratch[i][8*b +: 8] <= c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign s_bresp = bresp_q;

    rstate_e     r_state, r_next;
    logic        ar_hs;
    dec_t        r_dec;
    logic [31:0] r_val, rdata_q;
    logic [1:0]  r_resp, rresp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next    = r_state;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        ar_hs     = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_arready = 1'b1;
                ar_hs     = s_arvalid;
                if (ar_hs) r_next = R_RESP;
            end
            R_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        r_dec  = decode(s_araddr);
        r_val  = '0;
        r_resp = RESP_OKAY;
        case (r_dec.kind)
            K_SCR: begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    if (r_dec.idx == 10'(i)) r_val = scratch[i];
                end
            end
            K_ID:     r_val  = ID_VALUE;
            K_CNT_LO: r_val  = counter[31:0];
            K_CNT_HI: r_val  = shadow;
            K_MIS:    r_resp = RESP_SLVERR;
            default:  r_resp = RESP_DECERR;
        endcase
    end

    // Reading CNT_LO freezes the upper half so a following CNT_HI read pairs with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            shadow  <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            counter <= counter + 64'd1;
            if (ar_hs) begin
                rdata_q <= r_val;
                rresp_q <= r_resp;
                if (r_dec.kind == K_CNT_LO) shadow <= counter[63:32];
            end
        end
    end

    assign s_rdata = rdata_q;
    assign s_rresp = rresp_q;

endmodule

// File: tb/tb_axi_lite_periph_responder.sv
// tb/tb_axi_lite_periph_responder.sv - self-checking bench for axi_lite_periph_responder
module tb_axi_lite_periph_responder;

    localparam logic [31:0] BASE = 32'h6000_0000;
    localparam int          RC   = 8;
    localparam logic [31:0] IDV  = 32'hC5A5_0001;
    localparam int          NV   = 15;

    logic        clk, rst_n;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;

    int checks = 0;
    int errors = 0;

    logic [63:0] tb_cyc;
    logic [31:0] m_scr [RC];
    logic [31:0] m_shadow;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs [NV];

    axi_lite_periph_responder dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 64'd0;
        else        tb_cyc <= tb_cyc + 64'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < RC; i++) m_scr[i] = '0;
        m_shadow = '0;
    endtask

    function automatic logic [1:0] m_resp(input logic [31:0] a, input bit wr);
        logic [31:0] off;
        int          idx;
        off = a - BASE;
        if (off >= 32'd4096) return 2'b11;
        if (a % 4 != 0) return 2'b10;
        idx = int'(off / 4);
        if (idx < RC) return 2'b00;
        if (idx <= RC + 2) return wr ? 2'b10 : 2'b00;
        return 2'b11;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        int idx;
        if (m_resp(a, 1'b1) == 2'b00) begin
            idx = int'((a - BASE) / 4);
            for (int b = 0; b < 4; b++)
                if (st[b]) m_scr[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Called at the negedge before the AR handshake edge, where tb_cyc equals the live counter
    task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx;
        r = m_resp(a, 1'b0);
        d = '0;
        if (r == 2'b00) begin
            idx = int'((a - BASE) / 4);
            if (idx < RC) d = m_scr[idx];
            else if (idx == RC) d = IDV;
            else if (idx == RC + 1) begin
                d = tb_cyc[31:0];
                m_shadow = tb_cyc[63:32];
            end else d = m_shadow;
        end
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            input int lead, input int hold, output logic [1:0] resp);
        int aw_t, w_t, t;
        bit aw_done, w_done, aw_fire, w_fire;
        aw_t = (lead > 0) ? lead : 0;
        w_t  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; t = 0;
        while (!(aw_done && w_done) && t < 40) begin
            s_awaddr  = a;
            s_wdata   = d;
            s_wstrb   = st;
            s_awvalid = !aw_done && (t >= aw_t);
            s_wvalid  = !w_done && (t >= w_t);
            aw_fire   = s_awvalid && s_awready;
            w_fire    = s_wvalid && s_wready;
            @(posedge clk);
            aw_done |= aw_fire;
            w_done  |= w_fire;
            @(negedge clk);
            t++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
        chk("bvalid_next_cycle", {31'd0, s_bvalid}, 32'd1);
        chk("awready_in_resp", {31'd0, s_awready}, 32'd0);
        resp = s_bresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bvalid_hold", {31'd0, s_bvalid}, 32'd1);
            chk("bresp_hold", {30'd0, s_bresp}, {30'd0, resp});
            chk("awready_hold", {31'd0, s_awready}, 32'd0);
            chk("wready_hold", {31'd0, s_wready}, 32'd0);
        end
        s_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_bready = 1'b0;
        chk("bvalid_drop", {31'd0, s_bvalid}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold,
                           output logic [31:0] d, output logic [1:0] r,
                           output logic [31:0] ed, output logic [1:0] er);
        s_araddr  = a;
        s_arvalid = 1'b1;
        chk("arready_idle", {31'd0, s_arready}, 32'd1);
        m_read(a, ed, er);
        @(posedge clk);
        @(negedge clk);
        s_arvalid = 1'b0;
        chk("rvalid_next_cycle", {31'd0, s_rvalid}, 32'd1);
        d = s_rdata;
        r = s_rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rvalid_hold", {31'd0, s_rvalid}, 32'd1);
            chk("rdata_hold", s_rdata, d);
        end
        s_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_rready = 1'b0;
        chk("rvalid_drop", {31'd0, s_rvalid}, 32'd0);
    endtask

    logic [31:0] rd, ed, addr, wd;
    logic [1:0]  rr, er, br;
    logic [3:0]  st;

    initial begin
        vecs[0]  = '{1'b1, 32'h6000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h6000_0004, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h6000_0002, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[3]  = '{1'b1, 32'h6000_0020, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
        vecs[4]  = '{1'b0, 32'h6000_0020, 32'h0,         4'h0, 2'b00, 32'hC5A5_0001};
        vecs[5]  = '{1'b0, 32'h6000_0FFC, 32'h0,         4'h0, 2'b11, 32'h0};
        vecs[6]  = '{1'b0, 32'h7000_0000, 32'h0,         4'h0, 2'b11, 32'h0};
        vecs[7]  = '{1'b1, 32'h6000_0010, 32'hCAFE_F00D, 4'h0, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 32'h6000_0010, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[9]  = '{1'b1, 32'h6000_001C, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
        vecs[10] = '{1'b0, 32'h6000_001C, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
        vecs[11] = '{1'b1, 32'h6000_002C, 32'h0BAD_0BAD, 4'hF, 2'b11, 32'h0};
        vecs[12] = '{1'b1, 32'h6000_0024, 32'h0BAD_0BAD, 4'hF, 2'b10, 32'h0};
        vecs[13] = '{1'b1, 32'h6000_0003, 32'h0BAD_0BAD, 4'hF, 2'b10, 32'h0};
        vecs[14] = '{1'b0, 32'h5FFF_FFFC, 32'h0,         4'h0, 2'b11, 32'h0};

        rst_n = 1'b0;
        s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
        s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_awready", {31'd0, s_awready}, 32'd1);
        chk("rst_wready", {31'd0, s_wready}, 32'd1);
        chk("rst_arready", {31'd0, s_arready}, 32'd1);
        chk("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        chk("rst_bresp", {30'd0, s_bresp}, 32'd0);
        chk("rst_rresp", {30'd0, s_rresp}, 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_read(32'h6000_0028, 0, rd, rr, ed, er);
        chk("cnt_hi_before_lo", rd, 32'd0);
        chk("cnt_hi_before_lo_resp", {30'd0, rr}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, br);
                chk($sformatf("vec%0d_bresp", i), {30'd0, br}, {30'd0, vecs[i].resp});
                m_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                do_read(vecs[i].addr, 0, rd, rr, ed, er);
                chk($sformatf("vec%0d_rresp", i), {30'd0, rr}, {30'd0, vecs[i].resp});
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            end
        end

        do_write(32'h6000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, br);
        m_write(32'h6000_0000, 32'hFFFF_FFFF, 4'hF);
        do_write(32'h6000_0000, 32'h1122_3344, 4'h5, 3, 4, br);
        chk("w_lead_bresp", {30'd0, br}, 32'd0);
        m_write(32'h6000_0000, 32'h1122_3344, 4'h5);
        do_read(32'h6000_0000, 2, rd, rr, ed, er);
        chk("w_lead_readback", rd, 32'hFF22_FF44);

        do_read(32'h6000_0024, 0, rd, rr, ed, er);
        chk("cnt_lo", rd, ed);
        do_read(32'h6000_0028, 1, rd, rr, ed, er);
        chk("cnt_hi_shadow", rd, ed);
        chk("cnt_hi_zero", rd, 32'd0);

        do_write(32'h6000_0008, 32'hA5A5_A5A5, 4'hF, -1, 0, br);
        m_write(32'h6000_0008, 32'hA5A5_A5A5, 4'hF);
        s_awaddr = 32'h6000_0008; s_wdata = 32'h5A5A_5A5A; s_wstrb = 4'hF;
        s_araddr = 32'h6000_0008;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        m_read(32'h6000_0008, ed, er);
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chk("same_cycle_bvalid", {31'd0, s_bvalid}, 32'd1);
        chk("same_cycle_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("same_cycle_old_data", s_rdata, 32'hA5A5_A5A5);
        s_bready = 1'b1; s_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        m_write(32'h6000_0008, 32'h5A5A_5A5A, 4'hF);
        do_read(32'h6000_0008, 0, rd, rr, ed, er);
        chk("same_cycle_new_data", rd, 32'h5A5A_5A5A);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                8:       addr = BASE + $urandom_range(0, 4095);
                9:       addr = $urandom;
                default: addr = BASE + 4 * $urandom_range(0, 12);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                st = 4'($urandom_range(0, 15));
                do_write(addr, wd, st, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)), br);
                chk($sformatf("rnd%0d_bresp", n), {30'd0, br}, {30'd0, m_resp(addr, 1'b1)});
                m_write(addr, wd, st);
            end else begin
                do_read(addr, int'($urandom_range(0, 2)), rd, rr, ed, er);
                chk($sformatf("rnd%0d_rresp", n), {30'd0, rr}, {30'd0, er});
                chk($sformatf("rnd%0d_rdata", n), rd, ed);
            end
        end

        s_awaddr = 32'h6000_0000; s_wdata = 32'h0000_0077; s_wstrb = 4'hF;
        s_araddr = 32'h6000_0004;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chk("pre_rst_bvalid", {31'd0, s_bvalid}, 32'd1);
        chk("pre_rst_rvalid", {31'd0, s_rvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        chk("async_rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", {31'd0, s_awready}, 32'd1);
        chk("post_rst_wready", {31'd0, s_wready}, 32'd1);
        chk("post_rst_arready", {31'd0, s_arready}, 32'd1);
        do_read(32'h6000_0000, 0, rd, rr, ed, er);
        chk("post_rst_scratch0", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
